bsg_print_stat_event_buffer: RTL and testbench

Timestamped capture buffer that sits directly downstream of `bsg_print_stat_snoop` in the host-side IO complex. Each print-stat event the snoop flags is stored with the global cycle-counter value at detection. Events are held in a small FIFO until the host DPI layer drains them through a valid/yumi interface. Overflow is counted rather than back-pressured, because the snoop is passive and cannot stall the manycore link.

---
 rtl/bsg_print_stat_event_pkg.sv | 27 ++
 rtl/bsg_print_stat_event_fifo.sv | 77 +++++++
 rtl/bsg_print_stat_event_buffer.sv | 93 +++++++++
 tb/tb_bsg_print_stat_event_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_print_stat_event_pkg.sv
// ---------------------------------------------------------------------------
// bsg_print_stat_event_pkg : shared types and defaults for the event buffer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef BSG_PRINT_STAT_EVENT_PKG_SV
`define BSG_PRINT_STAT_EVENT_PKG_SV

// Entry layout is parameterized by the instantiating module's widths.
`define DECLARE_BSG_PRINT_STAT_EVENT_S(data_width_mp, ctr_width_mp) \
  typedef struct packed { \
    logic [data_width_mp-1:0] tag; \
    logic [ctr_width_mp-1:0]  timestamp; \
  } bsg_print_stat_event_s

package bsg_print_stat_event_pkg;

  localparam int default_els_lp        = 8;
  localparam int default_data_width_lp = 32;
  localparam int default_ctr_width_lp  = 64;

endpackage

`endif

`default_nettype wire

// File: rtl/bsg_print_stat_event_fifo.sv
// ---------------------------------------------------------------------------
// bsg_print_stat_event_fifo : circular buffer with registered head and count
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_print_stat_event_fifo
  import bsg_print_stat_event_pkg::*;
#(
  parameter  int width_p        = default_data_width_lp + default_ctr_width_lp,
  parameter  int els_p          = default_els_lp,
  localparam int ptr_width_lp   = $clog2(els_p),
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      push_i,
  input  logic [width_p-1:0]        data_i,
  input  logic                      pop_i,
  output logic [width_p-1:0]        data_o,
  output logic                      v_o,
  output logic                      full_o,
  output logic [count_width_lp-1:0] count_o
);

  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

  logic [width_p-1:0]        mem_q [els_p];
  logic [width_p-1:0]        mem_d [els_p];
  logic [ptr_width_lp-1:0]   wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]   rptr_q, rptr_d;
  logic [count_width_lp-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + ptr_width_lp'(1);
    end
    if (pop_i) begin
      rptr_d = rptr_q + ptr_width_lp'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + count_width_lp'(1);
      2'b01:   count_d = count_q - count_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o  = mem_q[rptr_q];
  assign v_o     = (count_q != '0);
  assign full_o  = (count_q == full_count_lp);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bsg_print_stat_event_buffer.sv
// ---------------------------------------------------------------------------
// bsg_print_stat_event_buffer : timestamped print-stat capture with drop count
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_print_stat_event_buffer
  import bsg_print_stat_event_pkg::*;
#(
  parameter  int data_width_p     = default_data_width_lp,
  parameter  int ctr_width_p      = default_ctr_width_lp,
  parameter  int els_p            = default_els_lp,
  parameter  int drop_ctr_width_p = 16,
  localparam int count_width_lp   = $clog2(els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        en_i,
  input  logic                        clear_i,
  input  logic                        print_stat_v_i,
  input  logic [data_width_p-1:0]     print_stat_tag_i,
  input  logic [ctr_width_p-1:0]      ctr_i,
  output logic                        v_o,
  output logic [data_width_p-1:0]     tag_o,
  output logic [ctr_width_p-1:0]      timestamp_o,
  input  logic                        yumi_i,
  output logic [count_width_lp-1:0]   count_o,
  output logic [drop_ctr_width_p-1:0] drop_count_o,
  output logic                        overflow_o
);

  `DECLARE_BSG_PRINT_STAT_EVENT_S(data_width_p, ctr_width_p);

  bsg_print_stat_event_s wr_event, rd_event;

  logic capture, push, pop, drop, full;
  logic [drop_ctr_width_p-1:0] drop_count_q, drop_count_d;
  logic                        overflow_q, overflow_d;

  assign capture            = en_i & print_stat_v_i;
  assign pop                = yumi_i & v_o;
  assign push               = capture & (~full | pop);
  assign drop               = capture & full & ~pop;
  assign wr_event.tag       = print_stat_tag_i;
  assign wr_event.timestamp = ctr_i;

  bsg_print_stat_event_fifo #(
    .width_p ($bits(bsg_print_stat_event_s)),
    .els_p   (els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (wr_event),
    .pop_i     (pop),
    .data_o    (rd_event),
    .v_o       (v_o),
    .full_o    (full),
    .count_o   (count_o)
  );

  // Clear takes effect before a same-cycle drop is accounted.
  always_comb begin
    drop_count_d = clear_i ? '0 : drop_count_q;
    overflow_d   = clear_i ? 1'b0 : overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_d != '1) begin
        drop_count_d = drop_count_d + drop_ctr_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign tag_o        = rd_event.tag;
  assign timestamp_o  = rd_event.timestamp;
  assign drop_count_o = drop_count_q;
  assign overflow_o   = overflow_q;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

`default_nettype wire

// File: tb/tb_bsg_print_stat_event_buffer.sv
// ---------------------------------------------------------------------------
// tb_bsg_print_stat_event_buffer : directed bench for the event buffer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bsg_print_stat_event_buffer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        en_i;
  logic        clear_i;
  logic        print_stat_v_i;
  logic [31:0] print_stat_tag_i;
  logic [63:0] ctr_i;
  logic        v_o;
  logic [31:0] tag_o;
  logic [63:0] timestamp_o;
  logic        yumi_i;
  logic [3:0]  count_o;
  logic [3:0]  drop_count_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;

  bsg_print_stat_event_buffer #(
    .data_width_p     (32),
    .ctr_width_p      (64),
    .els_p            (8),
    .drop_ctr_width_p (4)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .en_i             (en_i),
    .clear_i          (clear_i),
    .print_stat_v_i   (print_stat_v_i),
    .print_stat_tag_i (print_stat_tag_i),
    .ctr_i            (ctr_i),
    .v_o              (v_o),
    .tag_o            (tag_o),
    .timestamp_o      (timestamp_o),
    .yumi_i           (yumi_i),
    .count_o          (count_o),
    .drop_count_o     (drop_count_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic event_in(input logic [31:0] t, input logic [63:0] c);
    print_stat_v_i   = 1'b1;
    print_stat_tag_i = t;
    ctr_i            = c;
  endtask

  initial begin
    reset_n_i        = 1'b0;
    en_i             = 1'b1;
    clear_i          = 1'b0;
    print_stat_v_i   = 1'b0;
    print_stat_tag_i = '0;
    ctr_i            = '0;
    yumi_i           = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_drop", 64'(drop_count_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    reset_n_i = 1'b1;
    tick();

    // single event then pop
    event_in(32'h3, 64'd100);
    tick();
    print_stat_v_i = 1'b0;
    check("single_v", 64'(v_o), 64'd1);
    check("single_tag", 64'(tag_o), 64'h3);
    check("single_ts", timestamp_o, 64'd100);
    check("single_count", 64'(count_o), 64'd1);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check("single_pop_v", 64'(v_o), 64'd0);
    check("single_pop_count", 64'(count_o), 64'd0);

    // fill with 10 events, no pops
    for (int i = 0; i < 10; i++) begin
      event_in(32'h10 + 32'(i), 64'd200 + 64'(i));
      tick();
    end
    print_stat_v_i = 1'b0;
    check("fill_count", 64'(count_o), 64'd8);
    check("fill_drop", 64'(drop_count_o), 64'd2);
    check("fill_ovf", 64'(overflow_o), 64'd1);
    check("fill_head_tag", 64'(tag_o), 64'h10);
    check("fill_head_ts", timestamp_o, 64'd200);

    // full with simultaneous push and pop
    event_in(32'hAA, 64'd500);
    yumi_i = 1'b1;
    tick();
    print_stat_v_i = 1'b0;
    yumi_i = 1'b0;
    check("pp_count", 64'(count_o), 64'd8);
    check("pp_drop", 64'(drop_count_o), 64'd2);

    // drain: tags 0x11..0x17 then 0xAA
    for (int i = 0; i < 8; i++) begin
      check("drain_v", 64'(v_o), 64'd1);
      if (i < 7) begin
        check("drain_tag", 64'(tag_o), 64'h11 + 64'(i));
        check("drain_ts", timestamp_o, 64'd201 + 64'(i));
      end else begin
        check("drain_last_tag", 64'(tag_o), 64'hAA);
        check("drain_last_ts", timestamp_o, 64'd500);
      end
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
    end
    check("drain_empty_v", 64'(v_o), 64'd0);
    check("drain_empty_count", 64'(count_o), 64'd0);

    // clear alone, then fill 8 and drop 5
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_drop", 64'(drop_count_o), 64'd0);
    check("clr_ovf", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 13; i++) begin
      event_in(32'h20 + 32'(i), 64'd300 + 64'(i));
      tick();
    end
    print_stat_v_i = 1'b0;
    check("five_drop", 64'(drop_count_o), 64'd5);
    check("five_count", 64'(count_o), 64'd8);

    // clear plus drop in the same cycle
    event_in(32'h99, 64'd600);
    clear_i = 1'b1;
    tick();
    print_stat_v_i = 1'b0;
    check("clrdrop_drop", 64'(drop_count_o), 64'd1);
    check("clrdrop_ovf", 64'(overflow_o), 64'd1);
    tick();
    clear_i = 1'b0;
    check("clronly_drop", 64'(drop_count_o), 64'd0);
    check("clronly_ovf", 64'(overflow_o), 64'd0);
    check("clronly_count", 64'(count_o), 64'd8);

    // saturation: 20 drops into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      event_in(32'h40 + 32'(i), 64'd700 + 64'(i));
      tick();
    end
    print_stat_v_i = 1'b0;
    check("sat_drop", 64'(drop_count_o), 64'd15);
    check("sat_ovf", 64'(overflow_o), 64'd1);

    // disabled capture leaves everything alone
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      event_in(32'h55, 64'd800);
      tick();
    end
    print_stat_v_i = 1'b0;
    en_i = 1'b1;
    check("dis_drop", 64'(drop_count_o), 64'd15);
    check("dis_count", 64'(count_o), 64'd8);
    check("dis_head_tag", 64'(tag_o), 64'h20);
    check("dis_head_ts", timestamp_o, 64'd300);

    // drain to 3 entries, then reset mid-drain
    for (int i = 0; i < 5; i++) begin
      yumi_i = 1'b1;
      tick();
    end
    yumi_i = 1'b0;
    check("mid_count", 64'(count_o), 64'd3);
    check("mid_head_tag", 64'(tag_o), 64'h25);
    reset_n_i = 1'b0;
    #1;
    check("arst_v", 64'(v_o), 64'd0);
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_drop", 64'(drop_count_o), 64'd0);
    check("arst_ovf", 64'(overflow_o), 64'd0);
    tick();
    reset_n_i = 1'b1;
    tick();

    // first event after reset lands at slot 0
    event_in(32'h77, 64'd900);
    tick();
    print_stat_v_i = 1'b0;
    check("post_v", 64'(v_o), 64'd1);
    check("post_tag", 64'(tag_o), 64'h77);
    check("post_ts", timestamp_o, 64'd900);
    check("post_count", 64'(count_o), 64'd1);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check("post_pop_v", 64'(v_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
